// File: rtl/pipe_cia_adder.sv
// Pipelined carry-increment adder/subtractor with optional signed saturation.
// Each stage adds WIDTH/STAGES bits; a valid/ready handshake wraps the pipe.
module pipe_cia_adder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned BLOCK  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             of,
    output logic             satd
);

    localparam int unsigned SLICE = WIDTH / STAGES;
    localparam int unsigned NBLK  = SLICE / BLOCK;
    localparam int unsigned MSB   = WIDTH - 1;
    localparam int unsigned LAST  = STAGES - 1;

    // One pipeline register: operands travel along, s collects finished slices,
    // c is the carry into the next slice (carry-out of the MSB in the last stage).
    typedef struct packed {
        logic             v;
        logic             sat;
        logic             c;
        logic             of;
        logic             satd;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] bp;
        logic [WIDTH-1:0] s;
    } stage_t;

    stage_t             in_pk;
    stage_t             st_d [STAGES];
    stage_t             st_q [STAGES];
    logic [STAGES-1:0]  en;
    logic               acc;
    logic               advance;
    logic               unused_tail;

    function automatic stage_t stage_fn(stage_t src, int unsigned idx);
        stage_t       r;
        logic         cy;
        logic [BLOCK:0] x0;
        logic [BLOCK:0] x1;
        logic [BLOCK:0] xs;
        int unsigned  lo;
        r  = src;
        cy = src.c;
        for (int unsigned k = 0; k < NBLK; k++) begin
            lo = idx * SLICE + k * BLOCK;
            x0 = {1'b0, src.a[lo +: BLOCK]} + {1'b0, src.bp[lo +: BLOCK]};
            x1 = x0 + (BLOCK + 1)'(1);
            xs = cy ? x1 : x0;
            r.s[lo +: BLOCK] = xs[BLOCK-1:0];
            cy = xs[BLOCK];
        end
        r.c = cy;
        if (idx == LAST) begin
            r.of   = (src.a[MSB] == src.bp[MSB]) && (r.s[MSB] != src.a[MSB]);
            r.satd = src.sat && r.of;
            if (r.satd) begin
                r.s = {src.a[MSB], {(WIDTH-1){~src.a[MSB]}}};
            end
        end
        return r;
    endfunction

    assign out_valid = st_q[LAST].v;
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign sum       = st_q[LAST].s;
    assign cout      = st_q[LAST].c;
    assign of        = st_q[LAST].of;
    assign satd      = st_q[LAST].satd;

    always_comb begin
        in_pk     = '0;
        in_pk.v   = in_valid && in_ready;
        in_pk.sat = sat;
        in_pk.c   = cin ^ sub;
        in_pk.a   = a;
        in_pk.bp  = sub ? ~b : b;
    end

    always_comb begin
        for (int unsigned s = 0; s < STAGES; s++) begin
            st_d[s] = '0;
        end
        st_d[0] = stage_fn(in_pk, 0);
        for (int unsigned s = 1; s < STAGES; s++) begin
            st_d[s] = stage_fn(st_q[s-1], s);
        end
    end

    // A stage loads when it is empty or everything downstream moves, so bubbles
    // collapse during a stall while the output stage holds.
    always_comb begin
        acc = out_ready;
        en  = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            acc               = acc || !st_q[LAST-i].v;
            en[LAST-i]        = acc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < STAGES; s++) begin
                st_q[s] <= '0;
            end
        end else begin
            for (int unsigned s = 0; s < STAGES; s++) begin
                if (en[s]) begin
                    st_q[s] <= st_d[s];
                end
            end
        end
    end

    assign unused_tail = ^{st_q[LAST].a, st_q[LAST].bp, st_q[LAST].sat};

endmodule

// File: tb/tb_pipe_cia_adder.sv
// Self-checking bench for pipe_cia_adder: directed spec vectors, stall, reset
// and randomized traffic against an arithmetic reference scoreboard.
module tb_pipe_cia_adder;

    localparam int W  = 32;
    localparam int ST = 2;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          sub;
    logic          sat;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          cout;
    logic          of;
    logic          satd;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         of;
        logic         satd;
        int           acc_cyc;
        int           stalls;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   stall_cnt = 0;
    logic [W-1:0] b2b_exp [4];

    pipe_cia_adder #(.WIDTH(W), .BLOCK(4), .STAGES(ST)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .sat(sat),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .of(of), .satd(satd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic su, input logic sa);
        exp_t         r;
        logic [W-1:0] yp;
        logic [W:0]   raw;
        yp     = su ? ~y : y;
        raw    = {1'b0, x} + {1'b0, yp} + (W+1)'(ci ^ su);
        r.cout = raw[W];
        r.of   = (x[W-1] == yp[W-1]) && (raw[W-1] != x[W-1]);
        r.satd = sa && r.of;
        r.sum  = r.satd ? (x[W-1] ? 32'h8000_0000 : 32'h7fff_ffff) : raw[W-1:0];
        r.acc_cyc = 0;
        r.stalls  = 0;
        return r;
    endfunction

    // Scoreboard: accepted ops are predicted, delivered results popped in order.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            q.delete();
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_out", out_valid, 1'b0);
                end else begin
                    mon_e = q[0];
                    check("sb_sum", sum, mon_e.sum);
                    check("sb_cout", cout, mon_e.cout);
                    check("sb_of", of, mon_e.of);
                    check("sb_satd", satd, mon_e.satd);
                    if (out_ready) begin
                        if (stall_cnt == mon_e.stalls)
                            check("sb_latency", cyc - mon_e.acc_cyc, ST);
                        void'(q.pop_front());
                    end else begin
                        stall_cnt++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                mon_e = model(a, b, cin, sub, sat);
                mon_e.acc_cyc = cyc;
                mon_e.stalls  = stall_cnt;
                q.push_back(mon_e);
            end
        end
    end

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic su, input logic sa);
        bit ok;
        a = x; b = y; cin = ci; sub = su; sat = sa;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("send_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [W-1:0] es, input logic ec,
                              input logic eo, input logic ed);
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_sum"}, sum, es);
        check({tag, "_cout"}, cout, ec);
        check({tag, "_of"}, of, eo);
        check({tag, "_satd"}, satd, ed);
    endtask

    task automatic op_check(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic ci, input logic su, input logic sa,
                            input logic [W-1:0] es, input logic ec, input logic eo, input logic ed);
        send(x, y, ci, su, sa);
        repeat (ST-1) @(posedge clk);
        @(negedge clk);
        expect_out(tag, es, ec, eo, ed);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return 32'h7fff_ffff;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; a = '0; b = '0;
        cin = 1'b0; sub = 1'b0; sat = 1'b0; out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_valid", out_valid, 1'b0);
        check("rst_sum", sum, '0);
        check("rst_cout", cout, 1'b0);
        check("rst_of", of, 1'b0);
        check("rst_satd", satd, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        op_check("pos_ovf",     32'h7fffffff, 32'h7fffffff, 0, 0, 0, 32'hfffffffe, 0, 1, 0);
        op_check("pos_ovf_sat", 32'h7fffffff, 32'h7fffffff, 0, 0, 1, 32'h7fffffff, 0, 1, 1);
        op_check("neg_ovf",     32'h8fffffff, 32'h8fffffff, 0, 0, 0, 32'h1ffffffe, 1, 1, 0);
        op_check("neg_ovf_sat", 32'h8fffffff, 32'h8fffffff, 0, 0, 1, 32'h80000000, 1, 1, 1);
        op_check("sub_small",   32'h5,        32'h7,        0, 1, 0, 32'hfffffffe, 0, 0, 0);
        op_check("sub_sat",     32'h80000000, 32'h1,        0, 1, 1, 32'h80000000, 1, 1, 1);
        op_check("wrap",        32'hffffffff, 32'h1,        0, 0, 0, 32'h0,        1, 0, 0);
        op_check("sub_eq",      32'h1234,     32'h1234,     0, 1, 0, 32'h0,        1, 0, 0);

        b2b_exp[0] = 32'h7a9; b2b_exp[1] = 32'h15f;
        b2b_exp[2] = 32'hfffff246; b2b_exp[3] = 32'hffffffff;
        fork
            begin
                send(32'h7aa, 32'hffffffff, 0, 0, 0);
                send(32'haf,  32'haf,       1, 0, 0);
                send(32'h123, 32'hfffff123, 0, 0, 0);
                send(32'h0,   32'hffffffff, 0, 0, 0);
            end
            begin
                repeat (ST) @(posedge clk);
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("b2b_valid", out_valid, 1'b1);
                    check("b2b_sum", sum, b2b_exp[i]);
                end
            end
        join
        @(posedge clk);
        #1;

        out_ready = 1'b0;
        fork
            begin
                send(32'h11, 32'h22, 0, 0, 0);
                send(32'h33, 32'h44, 0, 0, 0);
                send(32'h55, 32'h66, 0, 0, 0);
            end
            begin
                repeat (3) @(negedge clk);
                check("stall_valid", out_valid, 1'b1);
                check("stall_in_ready", in_ready, 1'b0);
                check("stall_sum", sum, 32'h33);
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("stall_hold", sum, 32'h33);
                    check("stall_in_ready", in_ready, 1'b0);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk);
        check("stall_drain", q.size(), 0);
        @(posedge clk);
        #1;

        send(32'h1, 32'h2, 0, 0, 0);
        send(32'h3, 32'h4, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", out_valid, 1'b0);
        check("midrst_sum", sum, '0);
        check("midrst_in_ready", in_ready, 1'b1);
        in_valid = 1'b1; a = 32'h99; b = 32'h1;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("no_stale", out_valid, 1'b0);
        end
        @(posedge clk);
        #1;

        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            a         = pick();
            b         = pick();
            cin       = 1'($urandom);
            sub       = 1'($urandom);
            sat       = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 50 && q.size() != 0; k++) @(negedge clk);
        check("final_drain", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
